calc2_port_driver: RTL and testbench

- Host-side request engine sitting directly upstream of one calc2_top request port (reqN_*) and consuming that port's response (out_respN/out_dataN/out_tagN).
- Accepts whole two-operand commands via valid/ready, allocates one of four tags, and serialises each command into calc2's two-cycle request protocol.
- Tracks outstanding tags, captures tagged responses (in any order) and returns completed results to the host via valid/ready.
- One instance per calc2 port; four instances cover calc2_top.

---
 rtl/calc2_pkg.sv | 19 +
 rtl/calc2_tag_table.sv | 119 +++++++++++
 rtl/calc2_port_driver.sv | 92 +++++++++
 tb/tb_calc2_port_driver.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/calc2_pkg.sv
// rtl/calc2_pkg.sv - shared opcodes, response codes and state types for the calc2 port driver
package calc2_pkg;

  localparam int TAG_W = 2;

  localparam logic [3:0] CMD_ADD = 4'h1;
  localparam logic [3:0] CMD_SUB = 4'h2;
  localparam logic [3:0] CMD_SHL = 4'h5;
  localparam logic [3:0] CMD_SHR = 4'h6;

  localparam logic [1:0] RSP_NONE    = 2'd0;
  localparam logic [1:0] RSP_OK      = 2'd1;
  localparam logic [1:0] RSP_ERR     = 2'd2;
  localparam logic [1:0] RSP_TIMEOUT = 2'd3;

  typedef enum logic [1:0] {FREE, PEND, DONE} tag_state_t;
  typedef enum logic [1:0] {IDLE, OP1, OP2} send_state_t;

endpackage

// File: rtl/calc2_tag_table.sv
// rtl/calc2_tag_table.sv - per-tag state/resp/data store with lowest-free/lowest-done pick
// Optional per-tag response timeout counters under CALC2_TIMEOUT_EN (TIMEOUT must be >= 2).
module calc2_tag_table
  import calc2_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int TAG_N   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alloc,
  input  logic              arm,
  input  logic [TAG_W-1:0]  arm_tag,
  input  logic [1:0]        cap_resp,
  input  logic [TAG_W-1:0]  cap_tag,
  input  logic [DATA_W-1:0] cap_data,
  input  logic              pop,
  output logic              any_free,
  output logic [TAG_W-1:0]  free_tag,
  output logic              any_done,
  output logic [TAG_W-1:0]  done_tag,
  output logic [1:0]        done_resp,
  output logic [DATA_W-1:0] done_data,
  output logic              spurious
);

  tag_state_t        state [TAG_N];
  logic [1:0]        resp  [TAG_N];
  logic [DATA_W-1:0] data  [TAG_N];
  logic              cap_hit;
  logic [TAG_N-1:0]  expire;

  assign cap_hit = (cap_resp != RSP_NONE) && (state[cap_tag] == PEND);

  // Descending scan so the lowest matching index is the last one written.
  always_comb begin
    any_free = 1'b0;
    free_tag = '0;
    any_done = 1'b0;
    done_tag = '0;
    for (int i = TAG_N - 1; i >= 0; i--) begin
      if (state[i] == FREE) begin
        any_free = 1'b1;
        free_tag = TAG_W'(i);
      end
      if (state[i] == DONE) begin
        any_done = 1'b1;
        done_tag = TAG_W'(i);
      end
    end
  end

  assign done_resp = any_done ? resp[done_tag] : RSP_NONE;
  assign done_data = any_done ? data[done_tag] : '0;

`ifdef CALC2_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt   [TAG_N];
  logic             armed [TAG_N];

  always_comb begin
    expire = '0;
    for (int i = 0; i < TAG_N; i++) begin
      expire[i] = armed[i] && (state[i] == PEND) && (cnt[i] == CNT_W'(TIMEOUT - 1));
    end
  end

  // Count starts at 1 on the op2 edge so expiry lands TIMEOUT cycles after the op2 cycle.
  always_ff @(posedge clk) begin
    for (int i = 0; i < TAG_N; i++) begin
      if (reset || state[i] != PEND) begin
        armed[i] <= 1'b0;
        cnt[i]   <= '0;
      end else if (arm && arm_tag == TAG_W'(i)) begin
        armed[i] <= 1'b1;
        cnt[i]   <= CNT_W'(1);
      end else if (armed[i]) begin
        cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end
`else
  logic unused_timeout;
  assign expire         = '0;
  assign unused_timeout = ^{arm, arm_tag, TIMEOUT[0]};
`endif

  // Capture is written after expiry so a same-cycle response overrides the timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < TAG_N; i++) begin
        state[i] <= FREE;
        resp[i]  <= RSP_NONE;
        data[i]  <= '0;
      end
      spurious <= 1'b0;
    end else begin
      for (int i = 0; i < TAG_N; i++) begin
        if (expire[i]) begin
          state[i] <= DONE;
          resp[i]  <= RSP_TIMEOUT;
          data[i]  <= '0;
        end
      end
      if (alloc) state[free_tag] <= PEND;
      if (pop) state[done_tag] <= FREE;
      if (cap_hit) begin
        state[cap_tag] <= DONE;
        resp[cap_tag]  <= cap_resp;
        data[cap_tag]  <= cap_data;
      end else if (cap_resp != RSP_NONE) begin
        spurious <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/calc2_port_driver.sv
// rtl/calc2_port_driver.sv - host request engine serialising tagged commands onto one calc2 port
// Optional response timeout: define CALC2_TIMEOUT_EN.
module calc2_port_driver
  import calc2_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int TAG_N   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic              c_clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_cmd,
  input  logic [DATA_W-1:0] req_op1,
  input  logic [DATA_W-1:0] req_op2,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [1:0]        rsp_status,
  output logic [DATA_W-1:0] rsp_data,
  output logic [1:0]        rsp_tag,
  output logic [3:0]        calc_cmd_out,
  output logic [DATA_W-1:0] calc_data_out,
  output logic [1:0]        calc_tag_out,
  input  logic [1:0]        calc_resp_in,
  input  logic [DATA_W-1:0] calc_data_in,
  input  logic [1:0]        calc_tag_in,
  output logic              spurious_err
);

  send_state_t       state;
  logic [DATA_W-1:0] op2_q;
  logic              any_free;
  logic              any_done;
  logic [1:0]        free_tag;
  logic              accept;

  assign req_ready = ~reset & (state != OP1) & any_free;
  assign accept    = req_valid & req_ready;
  assign rsp_valid = any_done;

  // calc_tag_out keeps the allocated tag across OP1 and OP2.
  always_ff @(posedge c_clk) begin
    if (reset) begin
      state         <= IDLE;
      op2_q         <= '0;
      calc_cmd_out  <= '0;
      calc_data_out <= '0;
      calc_tag_out  <= '0;
    end else if (accept) begin
      state         <= OP1;
      op2_q         <= req_op2;
      calc_cmd_out  <= req_cmd;
      calc_data_out <= req_op1;
      calc_tag_out  <= free_tag;
    end else if (state == OP1) begin
      state         <= OP2;
      calc_cmd_out  <= '0;
      calc_data_out <= op2_q;
    end else begin
      state         <= IDLE;
      calc_cmd_out  <= '0;
      calc_data_out <= '0;
      calc_tag_out  <= '0;
    end
  end

  // A lower tag completing while a higher one waits takes over the presented slot.
  calc2_tag_table #(
    .DATA_W  (DATA_W),
    .TAG_N   (TAG_N),
    .TIMEOUT (TIMEOUT)
  ) u_tags (
    .clk       (c_clk),
    .reset     (reset),
    .alloc     (accept),
    .arm       (state == OP2),
    .arm_tag   (calc_tag_out),
    .cap_resp  (calc_resp_in),
    .cap_tag   (calc_tag_in),
    .cap_data  (calc_data_in),
    .pop       (any_done & rsp_ready),
    .any_free  (any_free),
    .free_tag  (free_tag),
    .any_done  (any_done),
    .done_tag  (rsp_tag),
    .done_resp (rsp_status),
    .done_data (rsp_data),
    .spurious  (spurious_err)
  );

endmodule

// File: tb/tb_calc2_port_driver.sv
// tb/tb_calc2_port_driver.sv - directed self-checking bench for calc2_port_driver
`timescale 1ns/1ps
module tb_calc2_port_driver;
  import calc2_pkg::*;

  localparam int DW  = 32;
  localparam int TMO = 8;

  logic          c_clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [3:0]    req_cmd;
  logic [DW-1:0] req_op1;
  logic [DW-1:0] req_op2;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [1:0]    rsp_status;
  logic [DW-1:0] rsp_data;
  logic [1:0]    rsp_tag;
  logic [3:0]    calc_cmd_out;
  logic [DW-1:0] calc_data_out;
  logic [1:0]    calc_tag_out;
  logic [1:0]    calc_resp_in;
  logic [DW-1:0] calc_data_in;
  logic [1:0]    calc_tag_in;
  logic          spurious_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 c_clk = ~c_clk;

  calc2_port_driver #(.DATA_W(DW), .TAG_N(4), .TIMEOUT(TMO)) dut (
    .c_clk         (c_clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_cmd       (req_cmd),
    .req_op1       (req_op1),
    .req_op2       (req_op2),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_status    (rsp_status),
    .rsp_data      (rsp_data),
    .rsp_tag       (rsp_tag),
    .calc_cmd_out  (calc_cmd_out),
    .calc_data_out (calc_data_out),
    .calc_tag_out  (calc_tag_out),
    .calc_resp_in  (calc_resp_in),
    .calc_data_in  (calc_data_in),
    .calc_tag_in   (calc_tag_in),
    .spurious_err  (spurious_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge c_clk);
    #1;
  endtask

  task automatic respond(input logic [1:0] r, input logic [1:0] t, input logic [DW-1:0] d);
    calc_resp_in = r;
    calc_tag_in  = t;
    calc_data_in = d;
    tick();
    calc_resp_in = '0;
    calc_tag_in  = '0;
    calc_data_in = '0;
  endtask

  task automatic pop();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  // Returns with the DUT in OP1 for the accepted command; tag is read off the bus.
  task automatic issue(input logic [3:0] c, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       output logic [1:0] tag);
    logic got = 1'b0;
    req_valid = 1'b1;
    req_cmd   = c;
    req_op1   = a;
    req_op2   = b;
    for (int i = 0; i < 20; i++) begin
      if (req_ready) begin
        got = 1'b1;
        tick();
        break;
      end
      tick();
    end
    req_valid = 1'b0;
    if (!got) check("issue_wait_ready", 64'd0, 64'd1);
    tag = calc_tag_out;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] t;
    int         n;
    logic       seen;

    reset = 1'b1;
    req_valid = 1'b0; req_cmd = '0; req_op1 = '0; req_op2 = '0;
    rsp_ready = 1'b0;
    calc_resp_in = '0; calc_data_in = '0; calc_tag_in = '0;
    tick();
    tick();

    check("rst_req_ready", req_ready, 0);
    check("rst_rsp", {rsp_valid, rsp_status, rsp_tag, rsp_data}, 0);
    check("rst_calc_bus", {calc_cmd_out, calc_data_out, calc_tag_out}, 0);
    check("rst_spurious", spurious_err, 0);

    reset = 1'b0;
    tick();
    check("idle_req_ready", req_ready, 1);

    req_valid = 1'b1; req_cmd = CMD_ADD; req_op1 = 32'h30; req_op2 = 32'h20;
    tick();
    req_valid = 1'b0;
    check("add_op1_bus", {calc_cmd_out, calc_data_out, calc_tag_out}, {4'h1, 32'h30, 2'd0});
    check("add_op1_ready", req_ready, 0);
    tick();
    check("add_op2_bus", {calc_cmd_out, calc_data_out, calc_tag_out}, {4'h0, 32'h20, 2'd0});
    respond(RSP_OK, 2'd0, 32'h50);
    check("add_rsp", {rsp_valid, rsp_status, rsp_tag, rsp_data}, {1'b1, 2'b01, 2'd0, 32'h50});
    check("add_idle_bus", {calc_cmd_out, calc_data_out, calc_tag_out}, 0);
    tick();
    check("add_rsp_hold", {rsp_valid, rsp_status, rsp_tag, rsp_data}, {1'b1, 2'b01, 2'd0, 32'h50});
    pop();
    check("add_popped", rsp_valid, 0);

`ifndef CALC2_TIMEOUT_EN
    issue(CMD_SUB, 32'd100, 32'd1, t);
    check("exh_tag0", t, 0);
    issue(CMD_SHL, 32'd1, 32'd4, t);
    check("exh_tag1", t, 1);
    issue(CMD_SHR, 32'h80, 32'd2, t);
    check("exh_tag2", t, 2);
    issue(CMD_ADD, 32'd3, 32'd4, t);
    check("exh_tag3", t, 3);
    tick();
    check("exh_ready_op2", req_ready, 0);
    tick();
    check("exh_ready_idle", req_ready, 0);
    respond(RSP_OK, 2'd1, 32'h11);
    check("exh_rsp", {rsp_valid, rsp_tag, rsp_data}, {1'b1, 2'd1, 32'h11});
    check("exh_ready_before_pop", req_ready, 0);
    pop();
    check("exh_ready_after_pop", req_ready, 1);
    issue(CMD_SUB, 32'd9, 32'd8, t);
    check("exh_reuse_tag", t, 1);
    tick();
    tick();

    respond(RSP_OK, 2'd2, 32'h7);
    check("ooo_tag2_shown", {rsp_valid, rsp_tag, rsp_data}, {1'b1, 2'd2, 32'h7});
    tick();
    check("ooo_tag2_hold", {rsp_valid, rsp_tag, rsp_data}, {1'b1, 2'd2, 32'h7});
    respond(RSP_OK, 2'd0, 32'h9);
    check("ooo_first", {rsp_valid, rsp_tag, rsp_data}, {1'b1, 2'd0, 32'h9});
    pop();
    check("ooo_second", {rsp_valid, rsp_tag, rsp_data}, {1'b1, 2'd2, 32'h7});
    pop();
    check("ooo_drained", rsp_valid, 0);

    respond(RSP_ERR, 2'd3, 32'hDEAD);
    check("err_rsp", {rsp_valid, rsp_status, rsp_tag, rsp_data}, {1'b1, 2'b10, 2'd3, 32'hDEAD});
    pop();

    check("spur_before", spurious_err, 0);
    respond(RSP_OK, 2'd3, 32'h1234);
    check("spur_no_valid", rsp_valid, 0);
    check("spur_set", spurious_err, 1);
    repeat (5) tick();
    check("spur_sticky", spurious_err, 1);

    issue(CMD_ADD, 32'd1, 32'd2, t);
    check("midrst_pre_tag", t, 0);
    tick();
    reset = 1'b1;
    tick();
    check("midrst_req_ready", req_ready, 0);
    check("midrst_rsp", {rsp_valid, rsp_status, rsp_tag, rsp_data}, 0);
    check("midrst_calc_bus", {calc_cmd_out, calc_data_out, calc_tag_out}, 0);
    check("midrst_spurious", spurious_err, 0);
    reset = 1'b0;
    tick();
    issue(CMD_ADD, 32'd5, 32'd6, t);
    check("postrst_op1_bus", {calc_cmd_out, calc_data_out, calc_tag_out}, {4'h1, 32'd5, 2'd0});
`endif

    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    issue(CMD_ADD, 32'd1, 32'd2, t);
    check("tmo_tag", t, 0);
    tick();

`ifdef CALC2_TIMEOUT_EN
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (rsp_valid) begin
        n = i;
        break;
      end
    end
    check("tmo_latency", n, TMO);
    check("tmo_rsp", {rsp_status, rsp_tag, rsp_data}, {2'b11, 2'd0, 32'd0});
    pop();
    respond(RSP_OK, 2'd0, 32'h55);
    check("tmo_late_no_valid", rsp_valid, 0);
    check("tmo_late_spurious", spurious_err, 1);
`else
    seen = 1'b0;
    repeat (80) begin
      tick();
      if (rsp_valid) seen = 1'b1;
    end
    check("no_timeout", seen, 0);
    respond(RSP_OK, 2'd0, 32'h3);
    check("late_rsp_ok", {rsp_valid, rsp_status, rsp_tag, rsp_data}, {1'b1, 2'b01, 2'd0, 32'h3});
    pop();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
